// File: rtl/demux1to2_stream_if.sv
// Stream bundle between the shared link, the demux and its two consumers.
interface demux1to2_stream_if #(
    parameter int unsigned WIDTH = 8
);
    localparam int unsigned CNT_W = 16;

    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             in_valid;
    logic             in_ready;

    logic [WIDTH-1:0] a_data;
    logic             a_valid;
    logic             a_ready;

    logic [WIDTH-1:0] b_data;
    logic             b_valid;
    logic             b_ready;

    logic [CNT_W-1:0] a_count;
    logic [CNT_W-1:0] b_count;

    // Link side plus consumers: drives words in, takes them out.
    modport master (
        output in_data, in_sel, in_valid, a_ready, b_ready,
        input  in_ready, a_data, a_valid, b_data, b_valid, a_count, b_count
    );

    // Demux side: accepts tagged words, presents two channels.
    modport slave (
        input  in_data, in_sel, in_valid, a_ready, b_ready,
        output in_ready, a_data, a_valid, b_data, b_valid, a_count, b_count
    );
endinterface

// File: rtl/demux1to2_stream.sv
// 1-to-2 stream demux: routes each tagged word into a per-channel FIFO
// (sel=0 -> A, sel=1 -> B) so a stalled consumer never blocks the other.
module demux1to2_stream #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    demux1to2_stream_if.slave    bus
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned N_CH  = 2;

    logic [N_CH-1:0]  full;
    logic [N_CH-1:0]  valid;
    logic [N_CH-1:0]  ready;
    logic [N_CH-1:0]  push;
    logic [N_CH-1:0]  pop;
    logic [WIDTH-1:0] head [N_CH];
    logic [CNT_W-1:0] xfer [N_CH];

    assign ready = {bus.b_ready, bus.a_ready};

    // Backpressure follows only the selected channel's registered full flag.
    assign bus.in_ready = ~full[bus.in_sel];

    for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
        logic [WIDTH-1:0] mem [DEPTH];
        logic [PTR_W-1:0] wr_ptr;
        logic [PTR_W-1:0] rd_ptr;
        logic [LVL_W-1:0] level;
        logic [CNT_W-1:0] count;

        assign push[ch]  = bus.in_valid && bus.in_ready && (bus.in_sel == 1'(ch));
        assign full[ch]  = (level == LVL_W'(DEPTH));
        assign valid[ch] = (level != '0);
        assign pop[ch]   = valid[ch] && ready[ch];
        assign head[ch]  = valid[ch] ? mem[rd_ptr] : '0;
        assign xfer[ch]  = count;

        // Pointer, fill level and transfer counter bookkeeping.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                level  <= '0;
                count  <= '0;
            end else begin
                if (push[ch]) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop[ch]) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                    count  <= count + CNT_W'(1);
                end
                case ({push[ch], pop[ch]})
                    2'b10:   level <= level + LVL_W'(1);
                    2'b01:   level <= level - LVL_W'(1);
                    default: level <= level;
                endcase
            end
        end

        // Storage needs no reset: the output is forced to zero while empty.
        always_ff @(posedge clk) begin
            if (push[ch]) begin
                mem[wr_ptr] <= bus.in_data;
            end
        end
    end

    assign bus.a_data  = head[0];
    assign bus.a_valid = valid[0];
    assign bus.a_count = xfer[0];
    assign bus.b_data  = head[1];
    assign bus.b_valid = valid[1];
    assign bus.b_count = xfer[1];
endmodule

// File: tb/tb_demux1to2_stream.sv
// Directed bench for demux1to2_stream with a queue scoreboard per channel.
`timescale 1ns/1ps
module tb_demux1to2_stream;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];

    demux1to2_stream_if #(.WIDTH(8)) bus ();

    demux1to2_stream #(.WIDTH(8), .DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one word until it is accepted; expected result queued on accept.
    task automatic send(input logic sel, input logic [7:0] d);
        bit done;
        done = 0;
        bus.in_valid = 1'b1;
        bus.in_sel   = sel;
        bus.in_data  = d;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                if (sel) exp_b.push_back(d);
                else     exp_a.push_back(d);
                done = 1;
            end
            tick();
        end
        bus.in_valid = 1'b0;
        if (!done) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        bit done;
        done = 0;
        for (int n = 0; n < 100 && !done; n++) begin
            @(negedge clk);
            if (exp_a.size() == 0 && exp_b.size() == 0 && !bus.a_valid && !bus.b_valid)
                done = 1;
        end
        tick();
        check("drain", 32'(done), 32'd1);
    endtask

    // Monitor: head of each channel must match the scoreboard while valid.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.a_valid) begin
                if (exp_a.size() == 0) begin
                    check("a_unexpected", 32'(bus.a_data), 32'hxxxx_xxxx);
                end else begin
                    check("a_data", 32'(bus.a_data), 32'(exp_a[0]));
                    if (bus.a_ready) void'(exp_a.pop_front());
                end
            end else begin
                check("a_data_idle", 32'(bus.a_data), 32'd0);
            end
            if (bus.b_valid) begin
                if (exp_b.size() == 0) begin
                    check("b_unexpected", 32'(bus.b_data), 32'hxxxx_xxxx);
                end else begin
                    check("b_data", 32'(bus.b_data), 32'(exp_b[0]));
                    if (bus.b_ready) void'(exp_b.pop_front());
                end
            end else begin
                check("b_data_idle", 32'(bus.b_data), 32'd0);
            end
        end
    end

    task automatic check_reset_state();
        check("rst_a_valid", 32'(bus.a_valid), 32'd0);
        check("rst_b_valid", 32'(bus.b_valid), 32'd0);
        check("rst_a_data",  32'(bus.a_data),  32'd0);
        check("rst_b_data",  32'(bus.b_data),  32'd0);
        check("rst_a_count", 32'(bus.a_count), 32'd0);
        check("rst_b_count", 32'(bus.b_count), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        rst_n        = 1'b0;
        bus.in_data  = '0;
        bus.in_sel   = 1'b0;
        bus.in_valid = 1'b0;
        bus.a_ready  = 1'b0;
        bus.b_ready  = 1'b0;
        tick();
        check_reset_state();
        tick();
        rst_n = 1'b1;

        // Routing with both consumers ready, one cycle latency.
        bus.a_ready = 1'b1;
        bus.b_ready = 1'b1;
        send(1'b0, 8'h11);
        check("route_a_valid", 32'(bus.a_valid), 32'd1);
        check("route_a_data",  32'(bus.a_data),  32'h11);
        send(1'b1, 8'h22);
        check("route_b_valid", 32'(bus.b_valid), 32'd1);
        check("route_b_data",  32'(bus.b_data),  32'h22);
        tick();
        check("route_a_count", 32'(bus.a_count), 32'd1);
        check("route_b_count", 32'(bus.b_count), 32'd1);

        // Reset in the middle of traffic discards buffered words.
        bus.a_ready = 1'b0;
        send(1'b0, 8'hA1);
        send(1'b0, 8'hA2);
        check("mid_a_full", 32'(bus.in_ready), 32'd0);
        rst_n = 1'b0;
        tick();
        exp_a.delete();
        exp_b.delete();
        check_reset_state();
        tick();
        rst_n = 1'b1;

        // Isolation: full B does not block A.
        bus.a_ready = 1'b1;
        bus.b_ready = 1'b0;
        send(1'b1, 8'hB0);
        send(1'b1, 8'hB1);
        bus.in_valid = 1'b1;
        bus.in_sel   = 1'b1;
        bus.in_data  = 8'hB2;
        @(negedge clk);
        check("iso_b_full_ready", 32'(bus.in_ready), 32'd0);
        tick();
        @(negedge clk);
        check("iso_b_held_ready", 32'(bus.in_ready), 32'd0);
        bus.in_sel  = 1'b0;
        bus.in_data = 8'h55;
        #1;
        check("iso_a_ready", 32'(bus.in_ready), 32'd1);
        exp_a.push_back(8'h55);
        tick();
        bus.in_valid = 1'b0;
        check("iso_b_head", 32'(bus.b_data), 32'hB0);
        bus.b_ready = 1'b1;
        drain();
        send(1'b1, 8'hB2);
        drain();

        // Full A with a pop in the same cycle: new word waits one cycle.
        bus.a_ready = 1'b0;
        send(1'b0, 8'h01);
        send(1'b0, 8'h02);
        bus.in_valid = 1'b1;
        bus.in_sel   = 1'b0;
        bus.in_data  = 8'h03;
        bus.a_ready  = 1'b1;
        @(negedge clk);
        check("fullpop_ready0", 32'(bus.in_ready), 32'd0);
        tick();
        @(negedge clk);
        check("fullpop_ready1", 32'(bus.in_ready), 32'd1);
        exp_a.push_back(8'h03);
        tick();
        bus.in_valid = 1'b0;
        drain();

        // Ordering under consumer backpressure.
        fork
            begin
                for (int i = 1; i <= 4; i++) send(1'b0, 8'(i));
            end
            begin
                for (int i = 0; i < 12; i++) begin
                    bus.a_ready = (i % 2 == 0);
                    tick();
                end
            end
        join
        bus.a_ready = 1'b1;
        drain();
        check("order_a_count", 32'(bus.a_count), 32'd8);
        check("order_b_count", 32'(bus.b_count), 32'd3);

        // Counter wrap on B: 3 + 65532 = 0xFFFF, one more wraps to 0.
        bus.b_ready = 1'b1;
        for (int i = 0; i < 65532; i++) send(1'b1, 8'(i));
        drain();
        check("wrap_b_ffff", 32'(bus.b_count), 32'hFFFF);
        send(1'b1, 8'h5A);
        drain();
        check("wrap_b_zero", 32'(bus.b_count), 32'd0);
        check("wrap_a_kept", 32'(bus.a_count), 32'd8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
